// File: rtl/shift_pkg.sv
// Mode encodings shared by the universal shift register and its users.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with clock enable, parallel load, shifts,
// rotates, arithmetic shift and synchronous clear.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero
);

    logic [WIDTH-1:0] q_next;

    // Shifts are built from whole-vector shifts plus a single-bit
    // patch so WIDTH = 1 never forms a negative part-select.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL: begin
                q_next    = q << 1;
                q_next[0] = sin_l;
            end
            MODE_SHR: begin
                q_next           = q >> 1;
                q_next[WIDTH-1]  = sin_r;
            end
            MODE_ROL: begin
                q_next    = q << 1;
                q_next[0] = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next          = q >> 1;
                q_next[WIDTH-1] = q[0];
            end
            MODE_ASR: begin
                q_next          = q >> 1;
                q_next[WIDTH-1] = q[WIDTH-1];
            end
            MODE_CLR: q_next = '0;
            default:  q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios, a WIDTH=1 instance
// and a randomized run against an arithmetic reference model.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       zero;

    logic       en1;
    logic [2:0] mode1;
    logic [0:0] d1;
    logic       sin_l1;
    logic       sin_r1;
    logic [0:0] q1;
    logic       sout_l1;
    logic       sout_r1;
    logic       zero1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q),
        .sout_l(sout_l), .sout_r(sout_r), .zero(zero)
    );

    univ_shift_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .mode(mode1), .d(d1),
        .sin_l(sin_l1), .sin_r(sin_r1), .q(q1),
        .sout_l(sout_l1), .sout_r(sout_r1), .zero(zero1)
    );

    // Reference: plain integer arithmetic on an 8-bit value.
    function automatic logic [7:0] model(
        input logic [2:0]  m,
        input int unsigned v,
        input int unsigned dv,
        input int unsigned sl,
        input int unsigned sr
    );
        int unsigned r;
        case (m)
            MODE_LOAD: r = dv;
            MODE_SHL:  r = (v * 2 + sl) % 256;
            MODE_SHR:  r = v / 2 + sr * 128;
            MODE_ROL:  r = (v * 2) % 256 + v / 128;
            MODE_ROR:  r = v / 2 + (v % 2) * 128;
            MODE_ASR:  r = v / 2 + (v / 128) * 128;
            MODE_CLR:  r = 0;
            default:   r = v;
        endcase
        return r[7:0];
    endfunction

    task automatic apply(input logic [2:0] m, input logic [7:0] dv,
                         input logic sl, input logic sr);
        mode  = m;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply1(input logic [2:0] m, input logic dv,
                          input logic sl, input logic sr);
        mode1  = m;
        d1     = dv;
        sin_l1 = sl;
        sin_r1 = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b1;
        mode  = MODE_LOAD;
        d     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_q got %h want a5", q);
        end
        n_cmp++;
        if ({zero, sout_l, sout_r} !== 3'b011) begin
            n_err++;
            $display("FAIL reset_flags got %b want 011",
                     {zero, sout_l, sout_r});
        end
        n_cmp++;
        if (q1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w1 got %b want 0", q1);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(MODE_HOLD, 8'h5A, 1'b1, 1'b1);
            n_cmp++;
            if (q !== 8'hA5) begin
                n_err++;
                $display("FAIL hold_%0d got %h want a5", i, q);
            end
        end
    endtask

    task automatic test_load_shift();
        logic [7:0] exp [5];
        exp = '{8'h3C, 8'h79, 8'h3C, 8'hC0, 8'hFF};
        apply(MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if (q !== exp[0]) begin
            n_err++;
            $display("FAIL load got %h want %h", q, exp[0]);
        end
        apply(MODE_SHL, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (q !== exp[1]) begin
            n_err++;
            $display("FAIL shl got %h want %h", q, exp[1]);
        end
        apply(MODE_SHR, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (q !== exp[2]) begin
            n_err++;
            $display("FAIL shr got %h want %h", q, exp[2]);
        end
        apply(MODE_LOAD, 8'h80, 1'b0, 1'b0);
        apply(MODE_ASR, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== exp[3]) begin
            n_err++;
            $display("FAIL asr80 got %h want %h", q, exp[3]);
        end
        apply(MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        apply(MODE_ASR, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== exp[4]) begin
            n_err++;
            $display("FAIL asrff got %h want %h", q, exp[4]);
        end
    endtask

    task automatic test_rotate();
        apply(MODE_LOAD, 8'h81, 1'b0, 1'b0);
        apply(MODE_ROL, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h03) begin
            n_err++;
            $display("FAIL rol81 got %h want 03", q);
        end
        apply(MODE_ROR, 8'h00, 1'b0, 1'b0);
        apply(MODE_ROR, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'hC0) begin
            n_err++;
            $display("FAIL ror2 got %h want c0", q);
        end
        apply(MODE_LOAD, 8'h81, 1'b0, 1'b0);
        repeat (8) apply(MODE_ROL, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h81) begin
            n_err++;
            $display("FAIL rol8 got %h want 81", q);
        end
        apply(MODE_LOAD, 8'h80, 1'b0, 1'b0);
        apply(MODE_ROL, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h01) begin
            n_err++;
            $display("FAIL rol80 got %h want 01", q);
        end
        apply(MODE_ROR, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h80) begin
            n_err++;
            $display("FAIL ror01 got %h want 80", q);
        end
    endtask

    task automatic test_enable();
        apply(MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        en = 1'b0;
        apply(MODE_CLR, 8'h12, 1'b0, 1'b0);
        apply(MODE_CLR, 8'h12, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'hFF) begin
            n_err++;
            $display("FAIL en_off got %h want ff", q);
        end
        apply(MODE_LOAD, 8'h12, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'hFF) begin
            n_err++;
            $display("FAIL en_off_load got %h want ff", q);
        end
        en = 1'b1;
        apply(MODE_CLR, 8'h12, 1'b0, 1'b0);
        n_cmp++;
        if (q !== 8'h00 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL clr got q=%h zero=%b want 00/1", q, zero);
        end
    endtask

    task automatic test_async_reset();
        apply(MODE_LOAD, 8'h01, 1'b0, 1'b0);
        apply(MODE_SHL, 8'h00, 1'b1, 1'b0);
        apply(MODE_SHL, 8'h00, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL async_rst got %h want a5", q);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        sin_l = 1'b0;
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL rst_hold got %h want a5", q);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 8'h4A) begin
            n_err++;
            $display("FAIL post_rst_shl got %h want 4a", q);
        end
    endtask

    task automatic test_random();
        logic [7:0] ref_q;
        logic [7:0] rd;
        logic [2:0] rm;
        logic       rl;
        logic       rr;
        logic       re;
        en = 1'b1;
        apply(MODE_LOAD, 8'h6B, 1'b0, 1'b0);
        ref_q = 8'h6B;
        for (int i = 0; i < 300; i++) begin
            rd = 8'($urandom);
            rm = 3'($urandom);
            rl = 1'($urandom);
            rr = 1'($urandom);
            re = ($urandom_range(0, 7) != 0);
            en = re;
            if (re)
                ref_q = model(rm, ref_q, rd, rl, rr);
            apply(rm, rd, rl, rr);
            n_cmp++;
            if (q !== ref_q) begin
                n_err++;
                $display("FAIL rand_%0d m=%0d got %h want %h",
                         i, rm, q, ref_q);
            end
            n_cmp++;
            if ({zero, sout_l, sout_r} !==
                {ref_q == 8'h00, ref_q[7], ref_q[0]}) begin
                n_err++;
                $display("FAIL rand_flags_%0d got %b for %h",
                         i, {zero, sout_l, sout_r}, ref_q);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_width1();
        logic [2:0] ms [6];
        logic       sl [6];
        logic       sr [6];
        logic       ex [6];
        ms = '{MODE_SHL, MODE_ROL, MODE_ASR, MODE_ROR,
               MODE_SHR, MODE_ROL};
        sl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        sr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ex = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply1(ms[i], 1'b0, sl[i], sr[i]);
            n_cmp++;
            if (q1 !== ex[i] || zero1 !== !ex[i] ||
                sout_l1 !== ex[i] || sout_r1 !== ex[i]) begin
                n_err++;
                $display("FAIL w1_%0d m=%0d got q=%b z=%b want %b",
                         i, ms[i], q1, zero1, ex[i]);
            end
        end
        apply1(MODE_LOAD, 1'b1, 1'b0, 1'b0);
        apply1(MODE_CLR, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (q1 !== 1'b0) begin
            n_err++;
            $display("FAIL w1_clr got %b want 0", q1);
        end
        en1 = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        mode   = MODE_HOLD;
        d      = 8'h00;
        sin_l  = 1'b0;
        sin_r  = 1'b0;
        en1    = 1'b0;
        mode1  = MODE_HOLD;
        d1     = 1'b0;
        sin_l1 = 1'b0;
        sin_r1 = 1'b0;
        test_reset();
        test_load_shift();
        test_rotate();
        test_enable();
        test_async_reset();
        test_random();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
